// File: rtl/mem_cache_pkg.sv
// Shared types and geometry helpers for the set-associative MEM-stage data cache.
package mem_cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } mc_state_t;

    typedef logic [63:0] mc_line_t;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - 3 - $clog2(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/mem_cache_lru.sv
// True-LRU age array per set: touch makes a way youngest, victim prefers invalid ways.
module mem_cache_lru
    import mem_cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 64,
    localparam int IDX_W = idx_w(SETS),
    localparam int WAY_W = way_w(WAYS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] idx,
    input  logic [WAYS-1:0]  valid,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim
);

    logic [WAY_W-1:0] age [SETS][WAYS];
    logic [WAY_W-1:0] touch_age;

    assign touch_age = age[idx][touch_way];

    // Oldest way is the fallback; the lowest-index invalid way overrides it.
    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (age[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w]) victim = WAY_W'(w);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= WAY_W'(w);
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age[idx][w] <= '0;
                else if (age[idx][w] < touch_age)
                    age[idx][w] <= age[idx][w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_cache_sa.sv
// N-way set-associative write-through, no-write-allocate data cache with LRU,
// single-cycle flush and load hit/miss counters.
module mem_cache_sa
    import mem_cache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    input  logic              flush,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [31:0]       sram_wdata,
    output logic              sram_r_en,
    output logic              sram_w_en,
    input  logic              sram_ready,
    input  logic [63:0]       sram_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS);
    localparam int WAY_W = way_w(WAYS);

    mc_state_t state, state_nxt;

    logic [WAYS-1:0]  valid [SETS];
    logic [TAG_W-1:0] tags  [SETS][WAYS];
    mc_line_t         lines [SETS][WAYS];

    logic             offset;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_byte_bits;

    // The set index sits just above the word-in-line bit.
    assign offset           = address[2];
    assign idx              = address[3 +: IDX_W];
    assign tag              = address[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^address[1:0];

    logic             hit;
    logic [WAY_W-1:0] hit_way, victim, touch_way;
    mc_line_t         hit_line;
    logic             hit_load, fill, wr_done, do_flush, touch;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid[idx][w] && tags[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line  = lines[idx][hit_way];
    assign hit_load  = (state == IDLE) && mem_r_en && !mem_w_en && hit;
    assign fill      = (state == RD_MISS) && sram_ready;
    assign wr_done   = (state == WR_THRU) && sram_ready;
    assign do_flush  = (state == IDLE) && flush && !mem_r_en && !mem_w_en;
    assign touch     = hit_load || fill || (wr_done && hit);
    assign touch_way = fill ? victim : hit_way;

    mem_cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk       (clk),
        .reset_n   (reset_n),
        .idx       (idx),
        .valid     (valid[idx]),
        .touch     (touch),
        .touch_way (touch_way),
        .victim    (victim)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_w_en)             state_nxt = WR_THRU;
                else if (mem_r_en && !hit) state_nxt = RD_MISS;
            end
            RD_MISS: if (sram_ready) state_nxt = IDLE;
            WR_THRU: if (sram_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready        = 1'b1;
        rdata        = '0;
        sram_r_en    = 1'b0;
        sram_w_en    = 1'b0;
        sram_address = '0;
        sram_wdata   = '0;
        case (state)
            IDLE: begin
                if (mem_w_en) begin
                    ready = 1'b0;
                end else if (mem_r_en) begin
                    ready = hit;
                    if (hit) rdata = offset ? hit_line[63:32] : hit_line[31:0];
                end
            end
            RD_MISS: begin
                sram_r_en    = 1'b1;
                sram_address = {address[ADDR_W-1:3], 3'b000};
                ready        = sram_ready;
                if (sram_ready) rdata = offset ? sram_rdata[63:32] : sram_rdata[31:0];
            end
            WR_THRU: begin
                sram_w_en    = 1'b1;
                sram_address = {address[ADDR_W-1:2], 2'b00};
                sram_wdata   = wdata;
                ready        = sram_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
        end else if (do_flush) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
        end else if (fill) begin
            valid[idx][victim] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[idx][victim]  <= tag;
            lines[idx][victim] <= sram_rdata;
        end else if (wr_done && hit) begin
            if (offset) lines[idx][hit_way][63:32] <= wdata;
            else        lines[idx][hit_way][31:0]  <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_load) hit_count  <= hit_count + 32'd1;
            if (fill)     miss_count <= miss_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_cache_sa.sv
// Bench for mem_cache_sa: a 2-way/64-set and a 4-way/16-set instance checked
// against a timestamp-LRU cache model and a line-addressed SRAM memory model.
module tb_mem_cache_sa;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        r_en [2], w_en [2], fl [2], rdy [2];
    logic        sram_ren [2], sram_wen [2], sram_rdy [2];
    logic [31:0] addr [2], wd [2], rdata [2], sram_a [2], sram_wd [2];
    logic [31:0] hitc [2], missc [2];
    logic [63:0] sram_rd [2];

    int n_cmp = 0;
    int n_fail = 0;

    mem_cache_sa #(.WAYS(2), .SETS(64), .ADDR_W(32)) dut0 (
        .clk(clk), .reset_n(reset_n), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
        .address(addr[0]), .wdata(wd[0]), .flush(fl[0]), .rdata(rdata[0]),
        .ready(rdy[0]), .sram_address(sram_a[0]), .sram_wdata(sram_wd[0]),
        .sram_r_en(sram_ren[0]), .sram_w_en(sram_wen[0]), .sram_ready(sram_rdy[0]),
        .sram_rdata(sram_rd[0]), .hit_count(hitc[0]), .miss_count(missc[0])
    );

    mem_cache_sa #(.WAYS(4), .SETS(16), .ADDR_W(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
        .address(addr[1]), .wdata(wd[1]), .flush(fl[1]), .rdata(rdata[1]),
        .ready(rdy[1]), .sram_address(sram_a[1]), .sram_wdata(sram_wd[1]),
        .sram_r_en(sram_ren[1]), .sram_w_en(sram_wen[1]), .sram_ready(sram_rdy[1]),
        .sram_rdata(sram_rd[1]), .hit_count(hitc[1]), .miss_count(missc[1])
    );

    // Backing memory, keyed by instance and line number.
    logic [63:0] mem [longint];

    // Cache model: per set/way a valid flag, line number and last-use timestamp.
    bit          mv    [2][64][4];
    logic [28:0] mline [2][64][4];
    longint      mlast [2][64][4];
    longint      stamp;
    int          exp_hits [2];
    int          exp_miss [2];

    function automatic int ways_of(input int u);
        return (u == 1) ? 4 : 2;
    endfunction

    function automatic int sets_of(input int u);
        return (u == 1) ? 16 : 64;
    endfunction

    function automatic longint mem_key(input int u, input logic [31:0] a);
        return longint'({u[0], a[31:3]});
    endfunction

    function automatic logic [63:0] mem_line(input int u, input logic [31:0] a);
        longint k = mem_key(u, a);
        if (mem.exists(k)) return mem[k];
        return {({a[31:3], 3'b100} ^ 32'h9E37_79B9), ({a[31:3], 3'b000} ^ 32'h7F4A_7C15)};
    endfunction

    function automatic logic [31:0] exp_word(input int u, input logic [31:0] a);
        logic [63:0] l = mem_line(u, a);
        return a[2] ? l[63:32] : l[31:0];
    endfunction

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int s = 0; s < 64; s++)
                for (int w = 0; w < 4; w++) begin
                    mv[u][s][w]    = 1'b0;
                    mlast[u][s][w] = -longint'(w);
                end
            exp_hits[u] = 0;
            exp_miss[u] = 0;
        end
        stamp = 0;
    endfunction

    function automatic void model_flush(input int u);
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++) mv[u][s][w] = 1'b0;
    endfunction

    // Returns whether the access hits; updates recency, fills on load miss.
    function automatic bit model_access(input int u, input bit st, input logic [31:0] a);
        int s  = int'(a[31:3]) % sets_of(u);
        int hw = -1;
        int v  = -1;
        for (int w = 0; w < ways_of(u); w++)
            if (mv[u][s][w] && mline[u][s][w] == a[31:3]) hw = w;
        stamp++;
        if (hw >= 0) begin
            mlast[u][s][hw] = stamp;
            if (!st) exp_hits[u]++;
            return 1'b1;
        end
        if (!st) begin
            for (int w = ways_of(u) - 1; w >= 0; w--)
                if (!mv[u][s][w]) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < ways_of(u); w++)
                    if (mlast[u][s][w] < mlast[u][s][v]) v = w;
            end
            mv[u][s][v]    = 1'b1;
            mline[u][s][v] = a[31:3];
            mlast[u][s][v] = stamp;
            exp_miss[u]++;
        end
        return 1'b0;
    endfunction

    // Presents one request and plays the SRAM side; returns observations only.
    task automatic drive(input int u, input bit st, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input bit fl_busy, output bit first_rdy,
                         output logic [31:0] rd, output int busy, output bit sram_ok);
        logic [31:0] exp_sa;
        logic [63:0] l;
        busy    = 0;
        sram_ok = 1'b1;
        rd      = '0;
        exp_sa  = st ? {a[31:2], 2'b00} : {a[31:3], 3'b000};
        @(negedge clk);
        addr[u] = a; wd[u] = d; w_en[u] = st; r_en[u] = !st;
        #1;
        first_rdy = rdy[u];
        if (first_rdy) begin
            rd = rdata[u];
        end else begin
            busy = 1;
            for (int k = 0; k <= lat; k++) begin
                @(negedge clk);
                if (fl_busy) fl[u] = 1'b1;
                if (k == lat) begin
                    sram_rdy[u] = 1'b1;
                    sram_rd[u]  = mem_line(u, a);
                end
                #1;
                if (sram_ren[u] !== !st || sram_wen[u] !== st || sram_a[u] !== exp_sa ||
                    (st && sram_wd[u] !== d)) sram_ok = 1'b0;
                if (k < lat) begin
                    if (rdy[u] !== 1'b0) sram_ok = 1'b0;
                    busy++;
                end else begin
                    if (rdy[u] !== 1'b1) busy++;
                    rd = rdata[u];
                end
            end
            if (st) begin
                l = mem_line(u, a);
                if (a[2]) l[63:32] = d; else l[31:0] = d;
                mem[mem_key(u, a)] = l;
            end
        end
        @(posedge clk);
        #1;
        r_en[u] = 1'b0; w_en[u] = 1'b0; sram_rdy[u] = 1'b0; fl[u] = 1'b0;
    endtask

    task automatic drive_flush(input int u, output bit r);
        @(negedge clk);
        fl[u] = 1'b1;
        #1;
        r = rdy[u];
        @(posedge clk);
        #1;
        fl[u] = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (rdy[u] !== 1'b1 || sram_ren[u] !== 1'b0 || sram_wen[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl u%0d: ready=%b r_en=%b w_en=%b want 1/0/0", u, rdy[u], sram_ren[u], sram_wen[u]);
            end
            n_cmp++;
            if (rdata[u] !== 32'h0 || sram_a[u] !== 32'h0 || sram_wd[u] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data u%0d: rdata=%h sram_address=%h sram_wdata=%h want 0", u, rdata[u], sram_a[u], sram_wd[u]);
            end
            n_cmp++;
            if (hitc[u] !== 32'h0 || missc[u] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_cnt u%0d: hit=%0d miss=%0d want 0/0", u, hitc[u], missc[u]);
            end
        end
    endtask

    task automatic test_cold_load();
        bit fr, ok;
        logic [31:0] rd;
        int busy;
        mem[mem_key(0, 32'h10)] = 64'h1111_2222_3333_4444;
        void'(model_access(0, 1'b0, 32'h10));
        drive(0, 1'b0, 32'h10, 32'h0, 2, 1'b0, fr, rd, busy, ok);
        n_cmp++;
        if (fr !== 1'b0 || busy != 3) begin
            n_fail++; $display("FAIL cold_stall: first_ready=%b stall=%0d want 0/3", fr, busy);
        end
        n_cmp++;
        if (rd !== 32'h3333_4444) begin n_fail++; $display("FAIL cold_rdata: got %h want 33334444", rd); end
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL cold_sram: handshake=%b want 1", ok); end
        n_cmp++;
        if (missc[0] !== 32'd1) begin n_fail++; $display("FAIL cold_miss_cnt: got %0d want 1", missc[0]); end
        void'(model_access(0, 1'b0, 32'h14));
        drive(0, 1'b0, 32'h14, 32'h0, 0, 1'b0, fr, rd, busy, ok);
        n_cmp++;
        if (fr !== 1'b1 || rd !== 32'h1111_2222) begin
            n_fail++; $display("FAIL reload_hit: ready=%b rdata=%h want 1/11112222", fr, rd);
        end
        n_cmp++;
        if (hitc[0] !== 32'd1) begin n_fail++; $display("FAIL reload_hit_cnt: got %0d want 1", hitc[0]); end
    endtask

    task automatic test_lru_evict();
        logic [31:0] seq [6] = '{32'h000, 32'h200, 32'h000, 32'h400, 32'h000, 32'h200};
        bit          eh  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bit fr, ok;
        logic [31:0] rd, ew;
        int busy;
        for (int i = 0; i < 6; i++) begin
            ew = exp_word(0, seq[i]);
            void'(model_access(0, 1'b0, seq[i]));
            drive(0, 1'b0, seq[i], 32'h0, 1, 1'b0, fr, rd, busy, ok);
            n_cmp++;
            if (fr !== eh[i] || rd !== ew) begin
                n_fail++;
                $display("FAIL lru_step%0d addr %h: hit=%b rdata=%h want %b/%h", i, seq[i], fr, rd, eh[i], ew);
            end
        end
    endtask

    task automatic test_store();
        bit fr, ok;
        logic [31:0] rd;
        int busy;
        void'(model_access(0, 1'b1, 32'h10));
        drive(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1, 1'b0, fr, rd, busy, ok);
        n_cmp++;
        if (fr !== 1'b0 || busy != 2 || ok !== 1'b1) begin
            n_fail++; $display("FAIL store_hit_wt: first_ready=%b stall=%0d handshake=%b want 0/2/1", fr, busy, ok);
        end
        void'(model_access(0, 1'b0, 32'h10));
        drive(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, fr, rd, busy, ok);
        n_cmp++;
        if (fr !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL store_updates_line: hit=%b rdata=%h want 1/deadbeef", fr, rd);
        end
        void'(model_access(0, 1'b1, 32'h80));
        drive(0, 1'b1, 32'h80, 32'h1234_5678, 0, 1'b0, fr, rd, busy, ok);
        void'(model_access(0, 1'b0, 32'h80));
        drive(0, 1'b0, 32'h80, 32'h0, 1, 1'b0, fr, rd, busy, ok);
        n_cmp++;
        if (fr !== 1'b0 || rd !== 32'h1234_5678) begin
            n_fail++; $display("FAIL store_no_alloc: hit=%b rdata=%h want 0/12345678", fr, rd);
        end
        n_cmp++;
        if (hitc[0] !== 32'(exp_hits[0]) || missc[0] !== 32'(exp_miss[0])) begin
            n_fail++; $display("FAIL store_counters: hit=%0d miss=%0d want %0d/%0d", hitc[0], missc[0], exp_hits[0], exp_miss[0]);
        end
    endtask

    task automatic test_flush();
        bit fr, ok, r;
        logic [31:0] rd, ew;
        int busy;
        drive_flush(0, r);
        model_flush(0);
        n_cmp++;
        if (r !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", r); end
        ew = exp_word(0, 32'h14);
        void'(model_access(0, 1'b0, 32'h14));
        drive(0, 1'b0, 32'h14, 32'h0, 1, 1'b0, fr, rd, busy, ok);
        n_cmp++;
        if (fr !== 1'b0 || rd !== ew) begin
            n_fail++; $display("FAIL flush_invalidates: hit=%b rdata=%h want 0/%h", fr, rd, ew);
        end
        void'(model_access(0, 1'b0, 32'h600));
        drive(0, 1'b0, 32'h600, 32'h0, 2, 1'b1, fr, rd, busy, ok);
        void'(model_access(0, 1'b0, 32'h600));
        drive(0, 1'b0, 32'h600, 32'h0, 0, 1'b0, fr, rd, busy, ok);
        n_cmp++;
        if (fr !== 1'b1) begin n_fail++; $display("FAIL flush_in_miss_ignored: hit=%b want 1", fr); end
    endtask

    task automatic test_reset_mid_miss();
        bit fr, ok;
        logic [31:0] rd;
        int busy;
        @(negedge clk);
        addr[0] = 32'hA00; r_en[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sram_ren[0] !== 1'b1) begin n_fail++; $display("FAIL mid_miss_rd_en: got %b want 1", sram_ren[0]); end
        reset_n = 1'b0;
        r_en[0] = 1'b0;
        #1;
        n_cmp++;
        if (sram_ren[0] !== 1'b0 || sram_wen[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++; $display("FAIL async_reset_ctrl: r_en=%b w_en=%b ready=%b want 0/0/1", sram_ren[0], sram_wen[0], rdy[0]);
        end
        n_cmp++;
        if (hitc[0] !== 32'h0 || missc[0] !== 32'h0) begin
            n_fail++; $display("FAIL async_reset_cnt: hit=%0d miss=%0d want 0/0", hitc[0], missc[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        void'(model_access(0, 1'b0, 32'h600));
        drive(0, 1'b0, 32'h600, 32'h0, 0, 1'b0, fr, rd, busy, ok);
        n_cmp++;
        if (fr !== 1'b0 || missc[0] !== 32'd1) begin
            n_fail++; $display("FAIL post_reset_miss: hit=%b miss=%0d want 0/1", fr, missc[0]);
        end
    endtask

    task automatic test_ways4();
        logic [31:0] seq [8] = '{32'h000, 32'h080, 32'h100, 32'h180, 32'h200, 32'h000, 32'h100, 32'h080};
        bit          eh  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bit fr, ok;
        logic [31:0] rd;
        logic [3:0] seen;
        int busy;
        for (int i = 0; i < 8; i++) begin
            void'(model_access(1, 1'b0, seq[i]));
            drive(1, 1'b0, seq[i], 32'h0, $urandom_range(0, 2), 1'b0, fr, rd, busy, ok);
            n_cmp++;
            if (fr !== eh[i]) begin
                n_fail++; $display("FAIL ways4_step%0d addr %h: hit=%b want %b", i, seq[i], fr, eh[i]);
            end
        end
        for (int s = 0; s < 16; s++) begin
            seen = '0;
            for (int w = 0; w < 4; w++) seen[dut1.u_lru.age[s][w]] = 1'b1;
            n_cmp++;
            if (seen !== 4'hF) begin n_fail++; $display("FAIL ages_perm set%0d: seen=%b want 1111", s, seen); end
        end
    endtask

    task automatic test_random();
        bit fr, ok, eh, r;
        logic [31:0] rd, ew, a, d;
        int busy, lat, u, op;
        for (int i = 0; i < 300; i++) begin
            u   = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 99));
            lat = int'($urandom_range(0, 3));
            a   = ($urandom_range(0, 5) << ((u == 1) ? 7 : 9)) | ($urandom_range(0, 3) << 3) |
                  ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            d   = $urandom;
            if (op < 8) begin
                drive_flush(u, r);
                model_flush(u);
                n_cmp++;
                if (r !== 1'b1) begin n_fail++; $display("FAIL rnd%0d flush_ready: got %b want 1", i, r); end
            end else if (op < 38) begin
                void'(model_access(u, 1'b1, a));
                drive(u, 1'b1, a, d, lat, 1'b0, fr, rd, busy, ok);
                n_cmp++;
                if (fr !== 1'b0 || busy != lat + 1 || ok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd%0d store u%0d %h: first_ready=%b stall=%0d handshake=%b want 0/%0d/1", i, u, a, fr, busy, ok, lat + 1);
                end
            end else begin
                ew = exp_word(u, a);
                eh = model_access(u, 1'b0, a);
                drive(u, 1'b0, a, 32'h0, lat, 1'b0, fr, rd, busy, ok);
                n_cmp++;
                if (fr !== eh || rd !== ew || (!eh && (busy != lat + 1 || ok !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL rnd%0d load u%0d %h: hit=%b rdata=%h stall=%0d handshake=%b want %b/%h/%0d/1", i, u, a, fr, rd, busy, ok, eh, ew, lat + 1);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (hitc[k] !== 32'(exp_hits[k]) || missc[k] !== 32'(exp_miss[k])) begin
                n_fail++;
                $display("FAIL rnd_counters u%0d: hit=%0d miss=%0d want %0d/%0d", k, hitc[k], missc[k], exp_hits[k], exp_miss[k]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            r_en[u] = 1'b0; w_en[u] = 1'b0; fl[u] = 1'b0; sram_rdy[u] = 1'b0;
            addr[u] = '0; wd[u] = '0; sram_rd[u] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_cold_load();
        test_lru_evict();
        test_store();
        test_flush();
        test_reset_mid_miss();
        test_ways4();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
